// File: rtl/helix_pkg.sv
// helix_pkg: shared defaults and types for the Helix loom/reservoir blocks.
//   HELIX_CONTEXT_W  : context vector width
//   HELIX_FEEDBACK_W : folded feedback delta width
//   HELIX_FOLD_DEPTH : default ctx FIFO depth for the loom fold
//   HELIX_FOLD_GAP   : default idle cycles enforced after each feedback emit
//   loom_fold_state_t: fold FSM state encoding
//   is_pow2()        : elaboration-time helper for FIFO depth checks
package helix_pkg;

    localparam int HELIX_CONTEXT_W  = 64;
    localparam int HELIX_FEEDBACK_W = 16;
    localparam int HELIX_FOLD_DEPTH = 4;
    localparam int HELIX_FOLD_GAP   = 2;

    typedef enum logic [1:0] {
        LF_IDLE = 2'd0,
        LF_FOLD = 2'd1,
        LF_EMIT = 2'd2,
        LF_GAP  = 2'd3
    } loom_fold_state_t;

    function automatic bit is_pow2(input int v);
        return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/helix_ctx_fifo.sv
// helix_ctx_fifo: synchronous FIFO with registered occupancy, shared by the
// loom fold and the reactor ingress.
//   clk, rst        : clock, synchronous active-high reset (contents lost)
//   push, wr_data   : write request (ignored when full) and its data
//   pop, rd_data    : read request (ignored when empty); rd_data shows the head
//   full, empty     : decoded from the registered level only, so a push at
//                     full is refused even when a pop happens in the same cycle
//   level           : current occupancy, 0..DEPTH
module helix_ctx_fifo
    import helix_pkg::*;
#(
    parameter int WIDTH = HELIX_CONTEXT_W,
    parameter int DEPTH = HELIX_FOLD_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/helix_loom_fold.sv
// helix_loom_fold_chk: elaboration-time parameter legality checks for the fold.
module helix_loom_fold_chk
    import helix_pkg::*;
#(
    parameter int CONTEXT_W  = HELIX_CONTEXT_W,
    parameter int FEEDBACK_W = HELIX_FEEDBACK_W,
    parameter int DEPTH      = HELIX_FOLD_DEPTH
) ();
    generate
        if ((CONTEXT_W % FEEDBACK_W) != 32'sd0) begin : g_bad_width
            $error("helix_loom_fold: CONTEXT_W must be a multiple of FEEDBACK_W");
        end
        if (!is_pow2(DEPTH) || (DEPTH < 32'sd2)) begin : g_bad_depth
            $error("helix_loom_fold: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate
endmodule

// helix_loom_fold: loom-side context/feedback engine. Buffers context vectors,
// XOR-folds each into a FEEDBACK_W delta (LSB chunk first) and returns it as a
// one-cycle pulse, with a gap counter standing in for the missing feedback ready.
//   clk, rst        : clock, synchronous active-high reset
//   ctx_valid/ready : context stream handshake, ctx_data sampled on push
//   feedback_valid  : one-cycle pulse, flop-driven
//   feedback_delta  : last emitted delta (flop)
//   busy            : FSM away from IDLE or FIFO holding data
//   fifo_level      : FIFO occupancy
//   emit_count      : pulses emitted, wrapping
module helix_loom_fold
    import helix_pkg::*;
#(
    parameter int CONTEXT_W     = HELIX_CONTEXT_W,
    parameter int FEEDBACK_W    = HELIX_FEEDBACK_W,
    parameter int DEPTH         = HELIX_FOLD_DEPTH,
    parameter int GAP_CYC       = HELIX_FOLD_GAP,
    parameter bit SUPPRESS_ZERO = 1'b1,
    parameter int EMIT_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctx_valid,
    output logic                    ctx_ready,
    input  logic [CONTEXT_W-1:0]    ctx_data,
    output logic                    feedback_valid,
    output logic [FEEDBACK_W-1:0]   feedback_delta,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [EMIT_CNT_W-1:0]   emit_count
);

    localparam int NCHUNK = CONTEXT_W / FEEDBACK_W;
    localparam int CNT_W  = (NCHUNK > 32'sd1) ? $clog2(NCHUNK) : 1;
    localparam int GAP_W  = (GAP_CYC > 32'sd1) ? $clog2(GAP_CYC) : 1;

    loom_fold_state_t         state_r;
    loom_fold_state_t         state_s;
    logic [CONTEXT_W-1:0]     sr_r;
    logic [FEEDBACK_W-1:0]    acc_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [GAP_W-1:0]         gap_r;
    logic                     fb_valid_r;
    logic [FEEDBACK_W-1:0]    fb_delta_r;
    logic [EMIT_CNT_W-1:0]    emit_cnt_r;

    logic                     push_s;
    logic                     pop_s;
    logic                     full_s;
    logic                     empty_s;
    logic [CONTEXT_W-1:0]     head_s;
    logic [FEEDBACK_W-1:0]    acc_next_s;
    logic                     last_chunk_s;
    logic                     fire_s;

    helix_loom_fold_chk #(
        .CONTEXT_W  (CONTEXT_W),
        .FEEDBACK_W (FEEDBACK_W),
        .DEPTH      (DEPTH)
    ) u_chk ();

    helix_ctx_fifo #(
        .WIDTH (CONTEXT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (ctx_data),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    assign ctx_ready      = ~full_s;
    assign push_s         = ctx_valid & ~full_s;
    assign pop_s          = (state_r == LF_IDLE) & ~empty_s;
    assign busy           = (state_r != LF_IDLE) | ~empty_s;
    assign feedback_valid = fb_valid_r;
    assign feedback_delta = fb_delta_r;
    assign emit_count     = emit_cnt_r;

    // Final-chunk decode. The emit decision is made on the last FOLD cycle so the
    // pulse flop is already high during the EMIT cycle itself.
    always_comb begin
        acc_next_s   = acc_r ^ sr_r[FEEDBACK_W-1:0];
        last_chunk_s = 1'b0;
        fire_s       = 1'b0;
        if ((state_r == LF_FOLD) && (cnt_r == CNT_W'(NCHUNK - 1))) begin
            last_chunk_s = 1'b1;
            if (SUPPRESS_ZERO && (acc_next_s == {FEEDBACK_W{1'b0}})) begin
                fire_s = 1'b0;
            end else begin
                fire_s = 1'b1;
            end
        end else begin
            last_chunk_s = 1'b0;
            fire_s       = 1'b0;
        end
    end

    // Fold FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LF_IDLE: begin
                if (!empty_s) begin
                    state_s = LF_FOLD;
                end else begin
                    state_s = LF_IDLE;
                end
            end
            LF_FOLD: begin
                if (last_chunk_s) begin
                    state_s = LF_EMIT;
                end else begin
                    state_s = LF_FOLD;
                end
            end
            LF_EMIT: begin
                // GAP is taken even after a suppressed pulse to keep cadence fixed.
                if (GAP_CYC > 32'sd0) begin
                    state_s = LF_GAP;
                end else begin
                    state_s = LF_IDLE;
                end
            end
            LF_GAP: begin
                if (gap_r == GAP_W'(GAP_CYC - 32'sd1)) begin
                    state_s = LF_IDLE;
                end else begin
                    state_s = LF_GAP;
                end
            end
            default: state_s = LF_IDLE;
        endcase
    end

    // Fold FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LF_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fold datapath, gap counter, pulse and emit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r       <= {CONTEXT_W{1'b0}};
            acc_r      <= {FEEDBACK_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            gap_r      <= {GAP_W{1'b0}};
            fb_valid_r <= 1'b0;
            fb_delta_r <= {FEEDBACK_W{1'b0}};
            emit_cnt_r <= {EMIT_CNT_W{1'b0}};
        end else begin
            fb_valid_r <= fire_s;
            if (fire_s) begin
                fb_delta_r <= acc_next_s;
                emit_cnt_r <= emit_cnt_r + EMIT_CNT_W'(1);
            end else begin
                fb_delta_r <= fb_delta_r;
                emit_cnt_r <= emit_cnt_r;
            end
            case (state_r)
                LF_IDLE: begin
                    if (!empty_s) begin
                        sr_r  <= head_s;
                        acc_r <= {FEEDBACK_W{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        sr_r  <= sr_r;
                    end
                end
                LF_FOLD: begin
                    acc_r <= acc_next_s;
                    sr_r  <= sr_r >> FEEDBACK_W;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                LF_EMIT: begin
                    gap_r <= {GAP_W{1'b0}};
                end
                LF_GAP: begin
                    gap_r <= gap_r + GAP_W'(1);
                end
                default: begin
                    gap_r <= {GAP_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_helix_loom_fold.sv
// tb_helix_loom_fold: directed bench for helix_loom_fold with a transaction-level
// reference model (FIFO queue + per-vector timing) compared every cycle, plus
// hand-computed literal expectations per scenario.
module tb_helix_loom_fold;

    localparam int NCH = 4;
    localparam int FW  = 16;
    localparam int GAP = 2;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctx_valid = 1'b0;
    logic [63:0] ctx_data = 64'h0;
    logic        ctx_ready;
    logic        feedback_valid;
    logic [15:0] feedback_delta;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [7:0]  emit_count;

    logic        nz_valid = 1'b0;
    logic [63:0] nz_data = 64'h0;
    logic        nz_ready;
    logic        nz_fv;
    logic [15:0] nz_delta;
    logic        nz_busy;
    logic [2:0]  nz_level;
    logic [7:0]  nz_emit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [63:0] mq[$];
    int          free_c = 0;
    int          pulse_c = -1;
    logic [15:0] pend_d = 16'h0;
    logic [15:0] e_delta = 16'h0;
    logic [7:0]  e_emit = 8'h0;
    logic        e_fv, e_ready, e_busy;
    logic [2:0]  e_level;

    // observed pulse log
    int          log_cyc[$];
    logic [15:0] log_d[$];
    logic [7:0]  log_e[$];

    helix_loom_fold dut (
        .clk(clk), .rst(rst), .ctx_valid(ctx_valid), .ctx_ready(ctx_ready),
        .ctx_data(ctx_data), .feedback_valid(feedback_valid),
        .feedback_delta(feedback_delta), .busy(busy), .fifo_level(fifo_level),
        .emit_count(emit_count)
    );

    helix_loom_fold #(.SUPPRESS_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .ctx_valid(nz_valid), .ctx_ready(nz_ready),
        .ctx_data(nz_data), .feedback_valid(nz_fv),
        .feedback_delta(nz_delta), .busy(nz_busy), .fifo_level(nz_level),
        .emit_count(nz_emit)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fold(input logic [63:0] v);
        logic [15:0] a;
        a = 16'h0;
        for (int i = 0; i < NCH; i++) a = a ^ v[i*FW +: FW];
        return a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_vec(input logic [63:0] v, output int t);
        int n;
        n = 0;
        ctx_valid = 1'b1;
        ctx_data  = v;
        while (ctx_ready !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        if (ctx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ctx_ready stuck at %b, required 1", ctx_ready);
        end
        t = cyc;
        tick(1);
        ctx_valid = 1'b0;
    endtask

    // Model + per-cycle compare, evaluated mid-cycle on the falling edge.
    initial begin
        logic [63:0] v;
        forever begin
            @(negedge clk);
            e_fv = 1'b0;
            if (cyc == pulse_c && !(pend_d == 16'h0)) begin
                e_fv    = 1'b1;
                e_delta = pend_d;
                e_emit  = e_emit + 8'd1;
            end
            e_level = 3'(mq.size());
            e_ready = (mq.size() != DEP);
            e_busy  = (cyc < free_c) || (mq.size() != 0);
            if (chk_en) begin
                chk("cyc_fv",    feedback_valid, e_fv);
                chk("cyc_delta", feedback_delta, e_delta);
                chk("cyc_emit",  emit_count,     e_emit);
                chk("cyc_level", fifo_level,     e_level);
                chk("cyc_ready", ctx_ready,      e_ready);
                chk("cyc_busy",  busy,           e_busy);
            end
            if (feedback_valid === 1'b1) begin
                log_cyc.push_back(cyc);
                log_d.push_back(feedback_delta);
                log_e.push_back(emit_count);
            end
            if (rst) begin
                mq.delete();
                free_c  = 0;
                pulse_c = -1;
                e_delta = 16'h0;
                e_emit  = 8'h0;
            end else begin
                if (cyc >= free_c && mq.size() != 0) begin
                    v       = mq.pop_front();
                    pend_d  = fold(v);
                    pulse_c = cyc + 1 + NCH;
                    free_c  = cyc + 2 + NCH + GAP;
                end
                if (ctx_valid && e_ready) mq.push_back(ctx_data);
            end
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, i0, seen, acc_nz;
        int tv[6];
        logic [63:0] vec3[6];
        logic [15:0] exp3[6];
        vec3 = '{64'h0001_0002_0004_0008, 64'hFFFF_0000_0000_0000, 64'h1111_2222_4444_0000,
                 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_00A5, 64'h8000_0000_0000_0001};
        exp3 = '{16'h000F, 16'hFFFF, 16'h7777, 16'h6042, 16'h00A5, 16'h8001};

        // reset
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", ctx_ready, 1'b1);
        chk("rst_fv", feedback_valid, 1'b0);
        chk("rst_delta", feedback_delta, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_emit", emit_count, 8'd0);

        // 1: single vector, pulse at T+6 with 0x000F
        i0 = log_cyc.size();
        push_vec(64'h0001_0002_0004_0008, t);
        tick(12);
        chk("t1_npulse", log_cyc.size() - i0, 1);
        if (log_cyc.size() > i0) begin
            chk("t1_cycle", log_cyc[i0], t + 6);
            chk("t1_delta", log_d[i0], 16'h000F);
        end
        chk("t1_emit", emit_count, 8'd1);

        // 2: zero fold is suppressed; busy drops at T+9
        i0 = log_cyc.size();
        push_vec(64'h1234_1234_0000_0000, t);
        tick(7);
        chk("t2_busy_t8", busy, 1'b1);
        tick(1);
        chk("t2_busy_t9", busy, 1'b0);
        tick(5);
        chk("t2_npulse", log_cyc.size() - i0, 0);
        chk("t2_emit", emit_count, 8'd1);

        // 2b: same vector with suppression off pulses 0x0000 at T+6
        nz_valid = 1'b1;
        nz_data  = 64'h1234_1234_0000_0000;
        t = cyc;
        chk("t2b_ready", nz_ready, 1'b1);
        tick(1);
        nz_valid = 1'b0;
        seen = -1;
        for (int k = 1; k <= 10; k++) begin
            if (nz_fv === 1'b1 && seen < 0) begin
                seen = cyc - t;
                chk("t2b_delta", nz_delta, 16'h0000);
            end
            tick(1);
        end
        chk("t2b_pulse_at", seen, 6);
        chk("t2b_emit", nz_emit, 8'd1);

        // 3: back-to-back vectors with valid held; FIFO fills, pulses 8 apart
        tick(3);
        i0 = log_cyc.size();
        for (int k = 0; k < 6; k++) push_vec(vec3[k], tv[k]);
        chk("t3_stall_push", tv[5], tv[0] + 10);
        tick(60);
        chk("t3_npulse", log_cyc.size() - i0, 6);
        for (int k = 0; k < 6; k++) begin
            if (log_cyc.size() > i0 + k) begin
                chk("t3_delta", log_d[i0 + k], exp3[k]);
                chk("t3_fold_ref", fold(vec3[k]), exp3[k]);
                chk("t3_cycle", log_cyc[i0 + k], tv[0] + 6 + 8 * k);
            end
        end

        // 4: reset during FOLD of vector 2 of 3
        tick(3);
        i0 = log_cyc.size();
        push_vec(64'h0000_0000_0000_0011, tv[0]);
        push_vec(64'h0000_0000_0000_0022, tv[1]);
        push_vec(64'h0000_0000_0000_0033, tv[2]);
        while (cyc < tv[0] + 11) tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t4_level", fifo_level, 3'd0);
        chk("t4_ready", ctx_ready, 1'b1);
        chk("t4_delta", feedback_delta, 16'h0);
        tick(40);
        chk("t4_npulse", log_cyc.size() - i0, 1);
        chk("t4_emit", emit_count, 8'd0);

        // 5: random valid gaps, concurrent push/pop; scoreboard via model
        acc_nz = 0;
        i0 = log_cyc.size();
        for (int k = 0; k < 80; k++) begin
            ctx_valid = ($urandom_range(0, 3) != 0);
            ctx_data  = {$urandom, $urandom};
            if (ctx_valid && ctx_ready === 1'b1 && fold(ctx_data) != 16'h0) acc_nz++;
            tick(1);
        end
        ctx_valid = 1'b0;
        tick(50);
        chk("t5_npulse", log_cyc.size() - i0, acc_nz);

        // 6: 256 non-zero folds, emit_count wraps on the 256th pulse
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        i0 = log_cyc.size();
        for (int k = 0; k < 256; k++) push_vec(64'(k + 1), t);
        tick(40);
        chk("t6_npulse", log_cyc.size() - i0, 256);
        if (log_cyc.size() >= i0 + 256) begin
            chk("t6_emit_255", log_e[i0 + 254], 8'hFF);
            chk("t6_emit_256", log_e[i0 + 255], 8'h00);
            chk("t6_delta_256", log_d[i0 + 255], 16'h0100);
        end
        chk("t6_emit_final", emit_count, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
